// File: rtl/radiant_scaler_rd_pkg.sv
// Shared types and constants for the scaler readback master.
package radiant_scaler_rd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_REQ  = 3'd2,
        ST_HOLD = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [7:0]  HDR_MAGIC = 8'hA5;
    localparam logic [31:0] ERR_WORD  = 32'hDEADDEAD;

    function automatic logic [31:0] build_header(input logic [7:0] count, input logic [15:0] seq);
        return {HDR_MAGIC, count, seq};
    endfunction

endpackage

// File: rtl/radiant_scaler_reader_engine.sv
// Single WISHBONE classic read with timeout, bounded retry and error substitution.
module wb_single_read_engine
    import radiant_scaler_rd_pkg::*;
#(
    parameter int TIMEOUT   = 255,
    parameter int MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [15:0] addr_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [15:0] wb_adr_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic        done_o,
    output logic [31:0] data_o,
    output logic        err_o
);

    localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
    localparam logic [7:0]  RETRY_MAX = 8'(MAX_RETRY);

    logic        gap_q, gap_d;
    logic [15:0] tmo_q, tmo_d;
    logic [7:0]  retry_q, retry_d;
    logic        active;

    assign active   = req_i && !gap_q;
    assign wb_cyc_o = active;
    assign wb_stb_o = active;
    assign wb_adr_o = addr_i;

    always_comb begin
        gap_d   = 1'b0;
        tmo_d   = tmo_q;
        retry_d = retry_q;
        done_o  = 1'b0;
        err_o   = 1'b0;
        data_o  = ERR_WORD;
        if (!req_i) begin
            tmo_d   = '0;
            retry_d = '0;
        end else if (gap_q) begin
            tmo_d = '0;
        end else if (wb_ack_i) begin
            done_o  = 1'b1;
            data_o  = wb_dat_i;
            tmo_d   = '0;
            retry_d = '0;
        end else if (wb_err_i || (wb_rty_i && retry_q == RETRY_MAX) || tmo_q == TMO_LAST) begin
            // the retry that would exceed the budget is handled as an error
            done_o  = 1'b1;
            err_o   = 1'b1;
            tmo_d   = '0;
            retry_d = '0;
        end else if (wb_rty_i) begin
            gap_d   = 1'b1;
            retry_d = retry_q + 8'd1;
            tmo_d   = '0;
        end else begin
            tmo_d = tmo_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gap_q   <= 1'b0;
            tmo_q   <= '0;
            retry_q <= '0;
        end else begin
            gap_q   <= gap_d;
            tmo_q   <= tmo_d;
            retry_q <= retry_d;
        end
    end

endmodule

// File: rtl/radiant_scaler_reader.sv
// Drains the scaler readback window over WISHBONE into a header-prefixed stream.
module radiant_scaler_reader #(
    parameter int          NUM_WORDS = 16,
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int          TIMEOUT   = 255,
    parameter int          MAX_RETRY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [15:0] wb_adr_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_rty_i,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy_o,
    output logic [7:0]  missed_o,
    output logic        error_o
);
    import radiant_scaler_rd_pkg::*;

    // 256 words wraps to 8'h00 in the header count field
    localparam logic [7:0] NW_CODE  = 8'(NUM_WORDS % 256);
    localparam logic [7:0] LAST_IDX = 8'(NUM_WORDS - 1);

    state_e      state_q, state_d;
    logic [15:0] seq_q, seq_d;
    logic [7:0]  idx_q, idx_d;
    logic [15:0] addr_q, addr_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  missed_q, missed_d;
    logic        error_q, error_d;

    logic        eng_done, eng_err;
    logic [31:0] eng_data;
    logic        is_last;

    wb_single_read_engine #(
        .TIMEOUT   (TIMEOUT),
        .MAX_RETRY (MAX_RETRY)
    ) u_engine (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (state_q == ST_REQ),
        .addr_i   (addr_q),
        .wb_cyc_o (wb_cyc_o),
        .wb_stb_o (wb_stb_o),
        .wb_adr_o (wb_adr_o),
        .wb_dat_i (wb_dat_i),
        .wb_ack_i (wb_ack_i),
        .wb_err_i (wb_err_i),
        .wb_rty_i (wb_rty_i),
        .done_o   (eng_done),
        .data_o   (eng_data),
        .err_o    (eng_err)
    );

    assign wb_we_o  = 1'b0;
    assign wb_sel_o = 4'hF;
    assign wb_dat_o = '0;

    assign is_last  = (idx_q == LAST_IDX);
    assign busy_o   = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign m_tvalid = (state_q == ST_HDR) || (state_q == ST_HOLD);
    assign m_tdata  = (state_q == ST_HDR) ? build_header(NW_CODE, seq_q) : word_q;
    assign m_tlast  = (state_q == ST_HOLD) && is_last;
    assign missed_o = missed_q;
    assign error_o  = error_q;

    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        idx_d    = idx_q;
        addr_d   = addr_q;
        word_d   = word_q;
        missed_d = missed_q;
        error_d  = error_q;

        if (start_i && state_q != ST_IDLE && missed_q != 8'hFF) begin
            missed_d = missed_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_HDR;
                    idx_d   = '0;
                    addr_d  = BASE_ADDR;
                end
            end
            ST_HDR: begin
                if (m_tready) begin
                    seq_d   = seq_q + 16'd1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (eng_done) begin
                    word_d  = eng_data;
                    state_d = ST_HOLD;
                    if (eng_err) begin
                        error_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (m_tready) begin
                    if (is_last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        addr_d  = addr_q + 16'd4;
                        state_d = ST_REQ;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            seq_q    <= '0;
            idx_q    <= '0;
            addr_q   <= BASE_ADDR;
            word_q   <= '0;
            missed_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            idx_q    <= idx_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            missed_q <= missed_d;
            error_q  <= error_d;
        end
    end

endmodule

// File: tb/tb_radiant_scaler_reader.sv
// Scoreboard bench: planned slave responses feed a reference model of the output stream.
module tb_radiant_scaler_reader;

    localparam int          NW   = 4;
    localparam int          TMO  = 8;
    localparam int          MR   = 3;
    localparam logic [15:0] BASE = 16'h0800;
    localparam logic [31:0] DEAD = 32'hDEADDEAD;
    localparam int F_ACK = 0, F_ERR = 1, F_NONE = 2, F_ALL = 3, F_ERRRTY = 4;

    typedef struct packed {
        logic [31:0] d;
        logic        l;
    } exp_t;

    logic        clk, rst, start, tready;
    logic        ack, err, rty;
    logic [31:0] dat_i;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [15:0] wb_adr_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_o, m_tdata;
    logic        m_tvalid, m_tlast, busy_o, error_o;
    logic [7:0]  missed_o;

    radiant_scaler_reader #(.NUM_WORDS(NW), .BASE_ADDR(BASE), .TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
        .wb_sel_o(wb_sel_o), .wb_dat_o(wb_dat_o), .wb_dat_i(dat_i),
        .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(tready), .m_tlast(m_tlast),
        .busy_o(busy_o), .missed_o(missed_o), .error_o(error_o)
    );

    int          checks = 0, errors = 0;
    exp_t        exp_q[$];
    logic [15:0] model_seq = 16'd0;
    logic        model_err = 1'b0;
    int          exp_missed = 0;
    int          p_wait[NW], p_rty[NW], p_fin[NW];
    logic [31:0] p_dat[NW];
    int          sweep_id = 0;
    int          rdy_pct = 100;
    logic        force_low = 1'b0, force_ack = 1'b0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic plan_all(input int fin, input int wt);
        for (int w = 0; w < NW; w++) begin
            p_fin[w] = fin; p_wait[w] = wt; p_rty[w] = 0; p_dat[w] = $urandom;
        end
    endtask

    task automatic plan_rand();
        int r;
        for (int w = 0; w < NW; w++) begin
            p_wait[w] = $urandom_range(0, 3);
            r = $urandom_range(0, 9);
            p_rty[w] = (r < 5) ? 0 : (r < 8) ? $urandom_range(1, 3) : 4;
            r = $urandom_range(0, 19);
            p_fin[w] = (r < 14) ? F_ACK : (r < 16) ? F_ERR : (r < 17) ? F_NONE : (r < 18) ? F_ALL : F_ERRRTY;
            p_dat[w] = $urandom;
        end
    endtask

    // Reference: a word is real data only if the retry budget held and the slave acked.
    task automatic start_sweep();
        exp_t e;
        e.d = {8'hA5, 8'(NW), model_seq};
        e.l = 1'b0;
        exp_q.push_back(e);
        model_seq = model_seq + 16'd1;
        for (int w = 0; w < NW; w++) begin
            if (p_rty[w] > MR || !(p_fin[w] == F_ACK || p_fin[w] == F_ALL)) begin
                e.d = DEAD;
                model_err = 1'b1;
            end else begin
                e.d = p_dat[w];
            end
            e.l = (w == NW - 1);
            exp_q.push_back(e);
        end
        sweep_id++;
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy_o && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy_o) check("idle_timeout", busy_o, 0);
        @(posedge clk);
    endtask

    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            tready = force_low ? 1'b0 : ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // WISHBONE slave following the per-word plan
    initial begin
        int att[NW];
        int seen, wcnt, hi_cnt, gap_chk, w;
        logic none_flag;
        logic [15:0] gap_adr, off;
        ack = 0; err = 0; rty = 0; dat_i = '0;
        seen = 0; wcnt = 0; hi_cnt = 0; gap_chk = 0; none_flag = 0; gap_adr = '0;
        for (int i = 0; i < NW; i++) att[i] = 0;
        forever begin
            @(negedge clk);
            if (seen != sweep_id) begin
                for (int i = 0; i < NW; i++) att[i] = 0;
                seen = sweep_id;
            end
            ack = 0; err = 0; rty = 0; dat_i = $urandom;
            if (force_ack) begin
                ack = 1;
            end else if (!wb_stb_o) begin
                if (gap_chk == 2) gap_chk = 1;
                else if (gap_chk == 1) begin
                    check("rty_reissue", wb_stb_o, 1);
                    gap_chk = 0;
                end
                if (none_flag) begin
                    check("timeout_len", hi_cnt, TMO);
                    none_flag = 0;
                end
                hi_cnt = 0; wcnt = 0;
            end else begin
                if (gap_chk == 2) begin
                    check("rty_gap_low", wb_stb_o, 0);
                    gap_chk = 0;
                end else if (gap_chk == 1) begin
                    check("rty_same_addr", wb_adr_o, gap_adr);
                    gap_chk = 0;
                end
                hi_cnt++;
                off = wb_adr_o - BASE;
                w = int'(off[3:2]);
                if (wcnt < p_wait[w]) begin
                    wcnt++;
                end else if (att[w] < p_rty[w]) begin
                    rty = 1;
                    if (att[w] < MR) begin
                        gap_chk = 2;
                        gap_adr = wb_adr_o;
                    end
                    att[w]++;
                end else begin
                    case (p_fin[w])
                        F_ACK:    begin ack = 1; dat_i = p_dat[w]; end
                        F_ERR:    err = 1;
                        F_NONE:   none_flag = 1;
                        F_ALL:    begin ack = 1; err = 1; rty = 1; dat_i = p_dat[w]; end
                        default:  begin err = 1; rty = 1; end
                    endcase
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every handshake and checks stream stability
    initial begin
        exp_t e;
        logic prev_stall;
        logic [31:0] prev_data;
        logic prev_last;
        prev_stall = 0; prev_data = '0; prev_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", m_tvalid, 1);
                    check("hold_data", m_tdata, prev_data);
                    check("hold_last", m_tlast, prev_last);
                end
                if (m_tvalid) check("no_stb_while_valid", wb_stb_o, 0);
                if (m_tvalid && tready) begin
                    check("queue_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("tdata", m_tdata, e.d);
                        check("tlast", m_tlast, e.l);
                    end
                end
                prev_stall = m_tvalid && !tready;
                prev_data  = m_tdata;
                prev_last  = m_tlast;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1; start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cyc", wb_cyc_o, 0);
        check("rst_stb", wb_stb_o, 0);
        check("rst_we", wb_we_o, 0);
        check("rst_sel", wb_sel_o, 4'hF);
        check("rst_dat_o", wb_dat_o, 0);
        check("rst_adr", wb_adr_o, BASE);
        check("rst_tvalid", m_tvalid, 0);
        check("rst_tlast", m_tlast, 0);
        check("rst_busy", busy_o, 0);
        check("rst_missed", missed_o, 0);
        check("rst_error", error_o, 0);
        rst = 0;

        plan_all(F_ACK, 1);
        wait_idle();
        start_sweep();
        @(negedge clk);
        check("hdr_valid_cycle1", m_tvalid, 1);
        check("busy_cycle1", busy_o, 1);
        n = 1;
        while (busy_o && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        check("busy_low_cycle", n, 14);
        wait_idle();
        check("basic_error", error_o, 0);

        plan_all(F_ACK, 0);
        start_sweep();
        repeat (3) begin
            @(posedge clk); #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
        exp_missed = 3;
        wait_idle();
        check("missed_overlap", missed_o, exp_missed);
        check("overlap_error", error_o, 0);

        plan_all(F_ACK, 1);
        p_fin[0] = F_ERR; p_wait[0] = 0;
        p_rty[1] = 2;
        p_fin[2] = F_NONE;
        p_wait[3] = 2;
        start_sweep();
        wait_idle();
        check("missed_after_done", missed_o, exp_missed);
        check("fault_error", error_o, 1);

        plan_all(F_ACK, 0);
        p_rty[1] = 4;
        start_sweep();
        wait_idle();
        check("rty4_error", error_o, model_err);

        rdy_pct = 60;
        repeat (30) begin
            plan_rand();
            start_sweep();
            wait_idle();
            check("rand_error", error_o, model_err);
        end

        rdy_pct = 100;
        plan_all(F_ACK, 0);
        force_low = 1;
        start_sweep();
        for (int i = 0; i < 300; i++) begin
            @(posedge clk); #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
        force_low = 0;
        exp_missed = (exp_missed + 300 > 255) ? 255 : exp_missed + 300;
        wait_idle();
        check("missed_saturate", missed_o, exp_missed);

        plan_all(F_ACK, 0);
        p_wait[2] = 3;
        start_sweep();
        n = 0;
        @(negedge clk);
        while (!(wb_stb_o && wb_adr_o == 16'h0808) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_word2", wb_adr_o, 16'h0808);
        rst = 1;
        exp_q.delete();
        model_seq = 16'd0;
        model_err = 1'b0;
        exp_missed = 0;
        @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        check("rst_mid_cyc", wb_cyc_o, 0);
        check("rst_mid_stb", wb_stb_o, 0);
        check("rst_mid_tvalid", m_tvalid, 0);
        check("rst_mid_missed", missed_o, 0);
        check("rst_mid_error", error_o, 0);
        force_ack = 1;
        repeat (3) begin
            @(negedge clk);
            check("late_ack_no_output", m_tvalid, 0);
        end
        force_ack = 0;
        plan_all(F_ACK, 1);
        wait_idle();
        start_sweep();
        wait_idle();
        check("post_rst_error", error_o, 0);

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
